// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a FIFO (empty/readEn/readData) and re-emits the
// words on a valid/ready stream, grouped into bursts marked with outLast.
// A burst closes after BurstLen beats, or early once the FIFO has stayed
// empty for TimeoutCycles while a word is held.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous reset, active-high
//   empty     - FIFO empty flag
//   readData  - FIFO head word, valid while empty=0
//   readEn    - FIFO pop (combinational)
//   outValid  - output word valid (registered)
//   outData   - output word (registered)
//   outLast   - last beat of a burst, qualified by outValid (registered)
//   outReady  - downstream accepts when outValid & outReady
module fifo_burst_reader #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned BurstLen      = 4,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 empty,
  input  logic [DataWidth-1:0] readData,
  output logic                 readEn,
  output logic                 outValid,
  output logic [DataWidth-1:0] outData,
  output logic                 outLast,
  input  logic                 outReady
);

  localparam int unsigned BeatW = (BurstLen > 1) ? $clog2(BurstLen) : 1;
  localparam int unsigned IdleW = $clog2(TimeoutCycles + 1);
  localparam logic [BeatW-1:0] BeatFinal = BeatW'(BurstLen - 1);
  localparam logic [IdleW-1:0] IdleMax   = IdleW'(TimeoutCycles);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [DataWidth-1:0] hold_data, hold_data_nxt;
  logic [DataWidth-1:0] out_data_nxt;
  logic                 out_valid_nxt, out_last_nxt;
  logic [BeatW-1:0]     beat_cnt, beat_cnt_nxt;
  logic [IdleW-1:0]     idle_cnt, idle_cnt_nxt;
  logic                 out_free, final_beat, advance, pop, close_burst;

  // Next-state and datapath decisions
  always_comb begin
    state_nxt     = state;
    hold_data_nxt = hold_data;
    out_data_nxt  = outData;
    out_valid_nxt = outValid;
    out_last_nxt  = outLast;
    beat_cnt_nxt  = beat_cnt;
    idle_cnt_nxt  = idle_cnt;

    out_free    = !outValid || outReady;
    final_beat  = (beat_cnt == BeatFinal);
    // Hand the held word on when it is final, has a successor, or has timed out
    advance     = (state == HOLD) && out_free &&
                  (final_beat || !empty || (idle_cnt == IdleMax));
    pop         = !rst && !empty && ((state == IDLE) || advance);
    // An advance while empty can only be a timeout, so it ends the burst
    close_burst = final_beat || empty;

    if (outValid && outReady) begin
      out_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (pop) begin
          hold_data_nxt = readData;
          idle_cnt_nxt  = '0;
          state_nxt     = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          out_data_nxt  = hold_data;
          out_valid_nxt = 1'b1;
          out_last_nxt  = close_burst;
          beat_cnt_nxt  = close_burst ? '0 : beat_cnt + BeatW'(1);
          if (pop) begin
            hold_data_nxt = readData;
            idle_cnt_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (empty) begin
          if (idle_cnt != IdleMax) begin
            idle_cnt_nxt = idle_cnt + IdleW'(1);
          end
        end else begin
          idle_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign readEn = pop;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_data <= '0;
      outData   <= '0;
      outValid  <= 1'b0;
      outLast   <= 1'b0;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      hold_data <= hold_data_nxt;
      outData   <= out_data_nxt;
      outValid  <= out_valid_nxt;
      outLast   <= out_last_nxt;
      beat_cnt  <= beat_cnt_nxt;
      idle_cnt  <= idle_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: a behavioural FIFO feeds the DUT, expected
// {last,data} beats go into a scoreboard queue, and a monitor compares every
// accepted output beat against it.
module tb_fifo_burst_reader;

  logic        clk;
  logic        rst;
  logic        empty;
  logic [31:0] read_data;
  logic        read_en;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] fq[$];
  logic [32:0] sb[$];
  logic        guard_mode;

  int unsigned cyc = 0;
  int unsigned pop_cyc, rise_cyc;
  int unsigned rise_cnt = 0;
  int unsigned hs_cnt = 0;
  int unsigned run = 0, max_run = 0;
  int unsigned hs_run = 0, max_hs_run = 0;

  fifo_burst_reader #(
    .DataWidth    (32),
    .BurstLen     (4),
    .TimeoutCycles(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .empty   (empty),
    .readData(read_data),
    .readEn  (read_en),
    .outValid(out_valid),
    .outData (out_data),
    .outLast (out_last),
    .outReady(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic last);
    fq.push_back(d);
    sb.push_back({last, d});
  endtask

  // Waits (bounded) until every queued word has been consumed and emitted
  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && fq.size() == 0 && !out_valid) break;
    end
    check(name, 64'(sb.size() + fq.size()), 64'd0);
  endtask

  task automatic wait_hs(input int unsigned target, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (hs_cnt >= target) break;
      @(negedge clk);
    end
    check(name, 64'(hs_cnt >= target), 64'd1);
  endtask

  // Behavioural FIFO: drives head/empty just after negedge, pops just before posedge
  initial begin
    empty     = 1'b1;
    read_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (guard_mode) begin
        empty     = 1'b1;
        read_data = $urandom;
      end else if (fq.size() == 0) begin
        empty     = 1'b1;
        read_data = $urandom;
      end else begin
        empty     = 1'b0;
        read_data = fq[0];
      end
      #3;
      if (empty) check("empty_guard", 64'(read_en), 64'd0);
      if (read_en && !empty) begin
        void'(fq.pop_front());
        pop_cyc = cyc;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  // Output monitor: scoreboard compare, stall stability, rise timing
  initial begin
    logic        stalled_prev;
    logic        prev_valid;
    logic [32:0] saved;
    logic [32:0] exp_beat;
    stalled_prev = 1'b0;
    prev_valid   = 1'b0;
    saved        = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        stalled_prev = 1'b0;
        prev_valid   = 1'b0;
      end else begin
        if (stalled_prev) check("stall_stable", 64'({out_last, out_data}), 64'(saved));
        if (out_valid && !prev_valid) begin
          rise_cyc = cyc;
          rise_cnt++;
        end
        prev_valid = out_valid;
        if (out_valid && out_ready) begin
          check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            exp_beat = sb.pop_front();
            check("out_data", 64'(out_data), 64'(exp_beat[31:0]));
            check("out_last", 64'(out_last), 64'(exp_beat[32]));
          end
          hs_cnt++;
          hs_run++;
          if (hs_run > max_hs_run) max_hs_run = hs_run;
        end else begin
          hs_run = 0;
        end
        stalled_prev = out_valid && !out_ready;
        saved        = {out_last, out_data};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int unsigned base;
    rst        = 1'b1;
    out_ready  = 1'b1;
    guard_mode = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #4;
    check("rst_readen", 64'(read_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);

    // Sustained drain: two full bursts back-to-back
    @(negedge clk);
    max_run    = 0;
    max_hs_run = 0;
    for (int i = 0; i < 8; i++) push_word(32'h10 + 32'(i), (i == 3) || (i == 7));
    wait_idle(100, "drain_t1");
    check("t1_pop_run", 64'(max_run), 64'd8);
    check("t1_out_run", 64'(max_hs_run), 64'd8);

    // Partial burst closed by timeout
    base = rise_cnt;
    push_word(32'hAA, 1'b1);
    for (int i = 0; i < 60; i++) begin
      if (rise_cnt > base) break;
      @(negedge clk);
    end
    check("t2_latency", 64'(rise_cyc - pop_cyc), 64'd18);
    wait_idle(60, "drain_t2");

    // Refill before timeout keeps the burst open
    push_word(32'h01, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (fq.size() == 0) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    push_word(32'h02, 1'b1);
    wait_idle(80, "drain_t3");

    // Backpressure mid-stream
    base = hs_cnt;
    for (int i = 0; i < 6; i++) push_word(32'h20 + 32'(i), (i == 3) || (i == 5));
    wait_hs(base + 2, 40, "t4_start");
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      #4;
      check("t4_stall_readen", 64'(read_en), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_idle(80, "drain_t4");
    check("t4_count", 64'(hs_cnt - base), 64'd6);

    // Empty guard with random head data
    guard_mode = 1'b1;
    repeat (20) @(negedge clk);
    guard_mode = 1'b0;

    // Reset mid-burst while holding the beat-2 word
    base = hs_cnt;
    push_word(32'h30, 1'b0);
    push_word(32'h31, 1'b0);
    fq.push_back(32'h32);
    wait_hs(base + 2, 40, "t5_start");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push_word(32'h40, 1'b0);
    push_word(32'h41, 1'b0);
    push_word(32'h42, 1'b0);
    push_word(32'h43, 1'b1);
    push_word(32'h44, 1'b1);
    #4;
    check("t5_rst_readen", 64'(read_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_data", 64'(out_data), 64'd0);
    check("t5_rst_last", 64'(out_last), 64'd0);
    @(negedge clk);
    wait_idle(100, "drain_t5");

    check("sb_left", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
